// File: rtl/jump_sequencer.sv
// jump_sequencer: frame-paced jump game sequencer (IDLE -> CHARGE -> FLY -> JUDGE -> IDLE/OVER).
// Define JUMP_SEQUENCER_CHEAT_EN to add a cheat input that turns a miss or timeout into a return to IDLE.
module jump_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       key_down,
  input  logic       restart,
  input  logic       land_valid,
  input  logic       land_ok,
`ifdef JUMP_SEQUENCER_CHEAT_EN
  input  logic       cheat,
`endif
  output logic       is_pressing,
  output logic [3:0] press_time,
  output logic       fly_start,
  output logic       flying,
  output logic [3:0] fly_left,
  output logic [7:0] score,
  output logic       score_pulse,
  output logic       game_over,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHARGE = 3'd1,
    FLY    = 3'd2,
    JUDGE  = 3'd3,
    OVER   = 3'd4
  } state_e;

  state_e     state_q;
  state_e     missState;
  logic [3:0] pressTime_q, pressTime_d;
  logic [3:0] flyLeft_q;
  logic [7:0] score_q, score_d;
  logic [2:0] judgeTimer_q;
  logic       isPressing_q, flyStart_q, flying_q, scorePulse_q, gameOver_q;
  logic       cheatEn;

`ifdef JUMP_SEQUENCER_CHEAT_EN
  assign cheatEn = cheat;
`else
  assign cheatEn = 1'b0;
`endif

  // Saturating increments and the destination of a failed landing
  assign pressTime_d = (pressTime_q == 4'hF) ? pressTime_q : pressTime_q + 4'd1;
  assign score_d     = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
  assign missState   = cheatEn ? IDLE : OVER;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pressTime_q  <= 4'd0;
      flyLeft_q    <= 4'd0;
      score_q      <= 8'd0;
      judgeTimer_q <= 3'd0;
      isPressing_q <= 1'b0;
      flyStart_q   <= 1'b0;
      flying_q     <= 1'b0;
      scorePulse_q <= 1'b0;
      gameOver_q   <= 1'b0;
    end else begin
      flyStart_q   <= 1'b0;
      scorePulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (frame_tick && key_down) begin
            pressTime_q  <= 4'd1;
            isPressing_q <= 1'b1;
            state_q      <= CHARGE;
          end
        end
        CHARGE: begin
          if (frame_tick) begin
            if (key_down) begin
              pressTime_q <= pressTime_d;
            end else begin
              flyLeft_q    <= pressTime_q;
              flyStart_q   <= 1'b1;
              isPressing_q <= 1'b0;
              flying_q     <= 1'b1;
              state_q      <= FLY;
            end
          end
        end
        FLY: begin
          if (frame_tick) begin
            flyLeft_q <= (flyLeft_q == 4'd0) ? 4'd0 : flyLeft_q - 4'd1;
            if (flyLeft_q <= 4'd1) begin
              flying_q     <= 1'b0;
              judgeTimer_q <= 3'd0;
              state_q      <= JUDGE;
            end
          end
        end
        // A landing report wins over a coinciding frame tick
        JUDGE: begin
          if (land_valid) begin
            if (land_ok) begin
              score_q      <= score_d;
              scorePulse_q <= 1'b1;
              state_q      <= IDLE;
            end else begin
              gameOver_q <= !cheatEn;
              state_q    <= missState;
            end
          end else if (frame_tick) begin
            if (judgeTimer_q == 3'd7) begin
              gameOver_q <= !cheatEn;
              state_q    <= missState;
            end else begin
              judgeTimer_q <= judgeTimer_q + 3'd1;
            end
          end
        end
        OVER: begin
          if (restart) begin
            score_q     <= 8'd0;
            pressTime_q <= 4'd0;
            flyLeft_q   <= 4'd0;
            gameOver_q  <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          isPressing_q <= 1'b0;
          flying_q     <= 1'b0;
          gameOver_q   <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign is_pressing = isPressing_q;
  assign press_time  = pressTime_q;
  assign fly_start   = flyStart_q;
  assign flying      = flying_q;
  assign fly_left    = flyLeft_q;
  assign score       = score_q;
  assign score_pulse = scorePulse_q;
  assign game_over   = gameOver_q;
  assign state       = state_q;

endmodule

// File: tb/tb_jump_sequencer.sv
// tb_jump_sequencer: randomized and directed stimulus, reference model feeds a queue that a
// separate monitor drains and compares against the jump_sequencer outputs every clock.
module tb_jump_sequencer;

  logic       clk = 1'b0;
  logic       rst, frame_tick, key_down, restart, land_valid, land_ok;
`ifdef JUMP_SEQUENCER_CHEAT_EN
  logic       cheat = 1'b0;
`endif
  logic       is_pressing, fly_start, flying, score_pulse, game_over;
  logic [3:0] press_time, fly_left;
  logic [7:0] score;
  logic [2:0] state;

  typedef struct packed {
    logic       isP;
    logic [3:0] press;
    logic       fs;
    logic       fl;
    logic [3:0] fly;
    logic [7:0] score;
    logic       sp;
    logic       go;
    logic [2:0] st;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   passed = 0;
  int   cycle  = 0;

  jump_sequencer dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .key_down(key_down),
    .restart(restart), .land_valid(land_valid), .land_ok(land_ok),
`ifdef JUMP_SEQUENCER_CHEAT_EN
    .cheat(cheat),
`endif
    .is_pressing(is_pressing), .press_time(press_time), .fly_start(fly_start),
    .flying(flying), .fly_left(fly_left), .score(score), .score_pulse(score_pulse),
    .game_over(game_over), .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: game-level bookkeeping with plain integers, one expected record per clock
  int   mSt = 0, mPress = 0, mFly = 0, mScore = 0, mTicks = 0;
  bit   mFlyStart, mPulse, cheatNow;
  exp_t e;

  always @(posedge clk) begin
`ifdef JUMP_SEQUENCER_CHEAT_EN
    cheatNow = cheat;
`else
    cheatNow = 1'b0;
`endif
    mFlyStart = 1'b0;
    mPulse    = 1'b0;
    if (rst) begin
      mSt = 0; mPress = 0; mFly = 0; mScore = 0; mTicks = 0;
    end else if (mSt == 0) begin
      if (frame_tick && key_down) begin mPress = 1; mSt = 1; end
    end else if (mSt == 1) begin
      if (frame_tick && key_down) mPress = (mPress + 1 > 15) ? 15 : mPress + 1;
      else if (frame_tick) begin mFly = mPress; mSt = 2; mFlyStart = 1'b1; end
    end else if (mSt == 2) begin
      if (frame_tick) begin
        mFly = (mFly > 0) ? mFly - 1 : 0;
        if (mFly == 0) begin mSt = 3; mTicks = 0; end
      end
    end else if (mSt == 3) begin
      if (land_valid && land_ok) begin
        mScore = (mScore + 1 > 255) ? 255 : mScore + 1;
        mPulse = 1'b1;
        mSt    = 0;
      end else if (land_valid) begin
        mSt = cheatNow ? 0 : 4;
      end else if (frame_tick) begin
        mTicks++;
        if (mTicks == 8) mSt = cheatNow ? 0 : 4;
      end
    end else if (mSt == 4) begin
      if (restart) begin mScore = 0; mPress = 0; mFly = 0; mSt = 0; end
    end
    e.isP   = (mSt == 1);
    e.press = 4'(mPress);
    e.fs    = mFlyStart;
    e.fl    = (mSt == 2);
    e.fly   = 4'(mFly);
    e.score = 8'(mScore);
    e.sp    = mPulse;
    e.go    = (mSt == 4);
    e.st    = 3'(mSt);
    expQ.push_back(e);
  end

  task automatic checkOutput();
    exp_t a, w;
    a = {is_pressing, press_time, fly_start, flying, fly_left, score, score_pulse, game_over, state};
    checks++;
    if (expQ.size() == 0) begin
      $display("[TB] FAIL cycle %0d outputs: got %h, required an expected entry (queue empty)", cycle, a);
      return;
    end
    w = expQ.pop_front();
    if (a === w) passed++;
    else
      $display("[TB] FAIL cycle %0d outputs: got st=%0d pt=%0d fl=%0d sc=%0d p/fs/f/sp/go=%b%b%b%b%b, required st=%0d pt=%0d fl=%0d sc=%0d p/fs/f/sp/go=%b%b%b%b%b",
               cycle, a.st, a.press, a.fly, a.score, a.isP, a.fs, a.fl, a.sp, a.go,
               w.st, w.press, w.fly, w.score, w.isP, w.fs, w.fl, w.sp, w.go);
  endtask

  always @(negedge clk) begin
    cycle++;
    checkOutput();
  end

  task automatic applyStimulus(input bit ft, input bit kd, input bit lv, input bit lo,
                               input bit rs, input bit rstv);
    frame_tick = ft;
    key_down   = kd;
    land_valid = lv;
    land_ok    = lo;
    restart    = rs;
    rst        = rstv;
    @(negedge clk);
  endtask

  task automatic doFlight(input int hold);
    for (int i = 0; i < hold; i++) applyStimulus(1, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < ((hold > 15) ? 15 : hold); i++) applyStimulus(1, 0, 0, 0, 0, 0);
  endtask

  task automatic doJump(input int hold, input bit ok);
    doFlight(hold);
    applyStimulus(0, 0, 1, ok, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);

    doJump(3, 1);
    doJump(20, 1);

    // Timeout in JUDGE, with a coinciding land_valid tick elsewhere, then restart
    doFlight(2);
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    doFlight(1);
    applyStimulus(1, 0, 1, 1, 0, 0);

    // Reset while five frames of flight remain
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Drive the score to saturation and beyond
    for (int i = 0; i < 258; i++) doJump(1, 1);
    doJump(1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);

`ifdef JUMP_SEQUENCER_CHEAT_EN
    doJump(2, 1);
    cheat = 1'b1;
    doJump(1, 0);
    doFlight(1);
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 0, 0, 0);
    cheat = 1'b0;
`endif

    for (int i = 0; i < 3000; i++) begin
`ifdef JUMP_SEQUENCER_CHEAT_EN
      cheat = ($urandom_range(0, 3) == 0);
`endif
      applyStimulus($urandom_range(0, 1) == 1,
                    $urandom_range(0, 2) != 0,
                    $urandom_range(0, 5) == 0,
                    $urandom_range(0, 2) != 0,
                    $urandom_range(0, 9) == 0,
                    $urandom_range(0, 199) == 0);
    end

    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (expQ.size() == 0) passed++;
    else $display("[TB] FAIL queue drain: got %0d leftover entries, required 0", expQ.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/jump_sequencer.md
JUMP_SEQUENCER -- requirements
Module: jump_sequencer

Interface
REQ-001 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  system clock; one clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-clk pulse per display frame update.
- key_down  in  1  debounced jump key level.
- restart  in  1  one-clk pulse; leaves OVER.
- land_valid  in  1  one-clk pulse; landing check result is present.
- land_ok  in  1  landing check result, sampled only with land_valid.
- is_pressing  out  1  high in CHARGE.
- press_time  out  4  charge length in frames.
- fly_start  out  1  one-clk pulse on CHARGE->FLY.
- flying  out  1  high in FLY.
- fly_left  out  4  frames of flight remaining.
- score  out  8  binary score.
- score_pulse  out  1  one-clk pulse per point.
- game_over  out  1  high in OVER.
- state  out  3  IDLE=0, CHARGE=1, FLY=2, JUDGE=3, OVER=4.

Function
REQ-002 The FSM SHALL advance only on clk edges with frame_tick=1, except in JUDGE and OVER, which react on any clk edge.
REQ-003 IDLE: when frame_tick=1 and key_down=1, the FSM SHALL load press_time=1 and go to CHARGE.
REQ-004 CHARGE: on frame_tick with key_down=1, press_time SHALL increment, saturating at 15.
REQ-005 CHARGE: on frame_tick with key_down=0, the FSM SHALL go to FLY, load fly_left=press_time and pulse fly_start for exactly one clk.
REQ-006 FLY: each frame_tick SHALL decrement fly_left. When fly_left is 1 before the decrement, the FSM SHALL go to JUDGE and clear the judge timer.
REQ-007 FLY/JUDGE: key_down SHALL be ignored, and press_time SHALL hold its value until the next CHARGE entry.
REQ-008 JUDGE, land_valid=1 and land_ok=1:
- score SHALL increment, saturating at 255.
- score_pulse SHALL be high for exactly one clk, including when score is already saturated.
- The FSM SHALL return to IDLE.
REQ-009 JUDGE, land_valid=1 and land_ok=0: the FSM SHALL go to OVER (see REQ-015 for the cheat case).
REQ-010 JUDGE: a 3-bit timer SHALL count frame_ticks. On the 8th frame_tick without land_valid, the FSM SHALL go to OVER.
REQ-011 When land_valid and frame_tick coincide in JUDGE, land_valid SHALL take priority.
REQ-012 OVER: game_over=1. restart=1 SHALL clear score, press_time and fly_left and go to IDLE. All other inputs SHALL be ignored.
REQ-013 Outputs SHALL be registered, with a latency of one clk from the qualifying input edge. Unused state encodings SHALL return to IDLE on the next clk.

Reset
REQ-014 When rst=1 at a clk edge:
- state SHALL go to IDLE.
- press_time, fly_left and score SHALL be 0.
- is_pressing, fly_start, flying, score_pulse and game_over SHALL be 0.
- The judge timer SHALL be 0.
- rst SHALL override all other inputs in any state, including mid-flight.

Configuration
REQ-015 Macro JUMP_SEQUENCER_CHEAT_EN controls a cheat input.
- Defined: a 1-bit input cheat SHALL exist. In JUDGE, a miss or timeout with cheat=1 SHALL return to IDLE without scoring and without a score_pulse.
- Not defined: the cheat port SHALL be absent, and every miss or timeout SHALL go to OVER.

Verification
REQ-016 Hold key_down for 3 frame_ticks, release at the 4th -> press_time=3, fly_start one pulse, 3 FLY frames, then state=3.
REQ-017 Hold key_down for 20 frame_ticks -> press_time saturates at 15, and fly_left=15 at FLY entry.
REQ-018 In JUDGE, land_valid=1, land_ok=1 with score=255 -> score stays 255, score_pulse=1 for one clk, state=0.
REQ-019 In JUDGE, 8 frame_ticks with no land_valid -> state=4, game_over=1. Then restart -> state=0, score=0.
REQ-020 Assert rst during FLY with fly_left=5 -> next clk: state=0, fly_left=0, flying=0.
REQ-021 With JUMP_SEQUENCER_CHEAT_EN defined and cheat=1, land_ok=0 in JUDGE -> state=0, score unchanged, game_over=0.
